// File: rtl/bus_pkg.sv
// Shared types for the bus fabric: the transaction-sequencing FSM state.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } bus_state_t;

endpackage

// File: rtl/bus_rr_arbiter.sv
// Round-robin selector: picks the first set request at or after the pointer,
// wrapping around, and returns it as a one-hot grant vector.
module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic found;

  // Scan candidates in pointer order; the first requester found wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (i == (int'(ptr) + k) % N)) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// Shared-bus fabric: round-robin arbitration between masters, address-decoded
// single-outstanding access to slaves, read-response routing with timeout.
module bus_fabric
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int NO_OF_MASTERS = 2,
  parameter int NO_OF_SLAVES  = 4,
  parameter int TIMEOUT       = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NO_OF_MASTERS-1:0]             m_req,
  input  logic [NO_OF_MASTERS-1:0]             m_wr,
  input  logic [NO_OF_MASTERS*ADDR_WIDTH-1:0]  m_addr,
  input  logic [NO_OF_MASTERS*DATA_WIDTH-1:0]  m_wdata,
  output logic [NO_OF_MASTERS-1:0]             m_gnt,
  output logic [NO_OF_MASTERS-1:0]             m_rvalid,
  output logic [NO_OF_MASTERS-1:0]             m_err,
  output logic [DATA_WIDTH-1:0]                m_rdata,
  output logic [NO_OF_SLAVES-1:0]              s_en,
  output logic                                 s_rd,
  output logic                                 s_wr,
  output logic [ADDR_WIDTH-1:0]                s_addr,
  output logic [DATA_WIDTH-1:0]                s_wdata,
  input  logic [NO_OF_SLAVES*DATA_WIDTH-1:0]   s_rdata,
  input  logic [NO_OF_SLAVES-1:0]              s_rvalid
);

  localparam int MW    = (NO_OF_MASTERS > 1) ? $clog2(NO_OF_MASTERS) : 1;
  localparam int SEL_W = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;
  localparam int CNT_W = 8;

  logic [ADDR_WIDTH-1:0] m_addr_arr  [NO_OF_MASTERS];
  logic [DATA_WIDTH-1:0] m_wdata_arr [NO_OF_MASTERS];
  logic [DATA_WIDTH-1:0] s_rdata_arr [NO_OF_SLAVES];

  for (genvar gi = 0; gi < NO_OF_MASTERS; gi++) begin : g_master_unpack
    assign m_addr_arr[gi]  = m_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_wdata_arr[gi] = m_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end
  for (genvar gi = 0; gi < NO_OF_SLAVES; gi++) begin : g_slave_unpack
    assign s_rdata_arr[gi] = s_rdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  bus_state_t state_reg, state_next;
  logic [MW-1:0]            ptr_reg, ptr_next;
  logic [CNT_W-1:0]         cnt_reg, cnt_next;
  logic [NO_OF_MASTERS-1:0] win_reg;
  logic                     wr_reg, dec_err_reg;
  logic [SEL_W-1:0]         sel_reg;
  logic                     capture;

  logic [NO_OF_MASTERS-1:0] arb_gnt;
  logic [MW-1:0]            arb_idx;
  logic [ADDR_WIDTH-1:0]    req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic                     req_wr;
  logic [SEL_W-1:0]         req_sel;
  logic                     req_dec_err;
  logic                     sel_rvalid;
  logic [DATA_WIDTH-1:0]    sel_rdata;

  logic [NO_OF_MASTERS-1:0] m_gnt_reg, m_gnt_next, m_rvalid_reg, m_rvalid_next;
  logic [NO_OF_MASTERS-1:0] m_err_reg, m_err_next;
  logic [DATA_WIDTH-1:0]    m_rdata_reg, m_rdata_next, s_wdata_reg, s_wdata_next;
  logic [NO_OF_SLAVES-1:0]  s_en_reg, s_en_next;
  logic                     s_rd_reg, s_rd_next, s_wr_reg, s_wr_next;
  logic [ADDR_WIDTH-1:0]    s_addr_reg, s_addr_next;

  bus_rr_arbiter #(.N(NO_OF_MASTERS), .PTR_W(MW)) u_arb (
    .req (m_req),
    .ptr (ptr_reg),
    .gnt (arb_gnt)
  );

  // Pull the winning master's index and request fields out of the flat buses.
  always_comb begin
    arb_idx   = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wr    = 1'b0;
    for (int i = 0; i < NO_OF_MASTERS; i++) begin
      if (arb_gnt[i]) begin
        arb_idx   = MW'(i);
        req_addr  = m_addr_arr[i];
        req_wdata = m_wdata_arr[i];
        req_wr    = m_wr[i];
      end
    end
  end

  assign req_sel     = req_addr[ADDR_WIDTH-1 -: SEL_W];
  assign req_dec_err = (int'(req_sel) >= NO_OF_SLAVES);

  // Only the addressed slave's response is visible to the FSM.
  always_comb begin
    sel_rvalid = 1'b0;
    sel_rdata  = '0;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      if (sel_reg == SEL_W'(i)) begin
        sel_rvalid = s_rvalid[i];
        sel_rdata  = s_rdata_arr[i];
      end
    end
  end

  // Next-state and next-output logic; every output defaults to its idle value.
  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    cnt_next      = cnt_reg;
    capture       = 1'b0;
    m_gnt_next    = '0;
    m_rvalid_next = '0;
    m_err_next    = '0;
    m_rdata_next  = '0;
    s_en_next     = '0;
    s_rd_next     = 1'b0;
    s_wr_next     = 1'b0;
    s_addr_next   = '0;
    s_wdata_next  = '0;
    case (state_reg)
      IDLE: begin
        if (|m_req) begin
          capture    = 1'b1;
          state_next = ISSUE;
          ptr_next   = (arb_idx == MW'(NO_OF_MASTERS - 1)) ? '0 : arb_idx + MW'(1);
          m_gnt_next = arb_gnt;
          if (req_dec_err) begin
            m_err_next = arb_gnt;
          end else begin
            for (int i = 0; i < NO_OF_SLAVES; i++) begin
              s_en_next[i] = (req_sel == SEL_W'(i));
            end
            s_rd_next    = ~req_wr;
            s_wr_next    = req_wr;
            s_addr_next  = req_addr;
            s_wdata_next = req_wdata;
          end
        end
      end
      ISSUE: begin
        if (dec_err_reg || wr_reg) begin
          state_next = IDLE;
        end else begin
          state_next = WAIT_RD;
          cnt_next   = '0;
        end
      end
      WAIT_RD: begin
        if (sel_rvalid) begin
          state_next    = IDLE;
          m_rvalid_next = win_reg;
          m_rdata_next  = sel_rdata;
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          state_next    = IDLE;
          m_rvalid_next = win_reg;
          m_err_next    = win_reg;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM, pointer and timeout counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Hold the winner's identity and decode result for the rest of the transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_reg     <= '0;
      wr_reg      <= 1'b0;
      sel_reg     <= '0;
      dec_err_reg <= 1'b0;
    end else if (capture) begin
      win_reg     <= arb_gnt;
      wr_reg      <= req_wr;
      sel_reg     <= req_sel;
      dec_err_reg <= req_dec_err;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_gnt_reg    <= '0;
      m_rvalid_reg <= '0;
      m_err_reg    <= '0;
      m_rdata_reg  <= '0;
      s_en_reg     <= '0;
      s_rd_reg     <= 1'b0;
      s_wr_reg     <= 1'b0;
      s_addr_reg   <= '0;
      s_wdata_reg  <= '0;
    end else begin
      m_gnt_reg    <= m_gnt_next;
      m_rvalid_reg <= m_rvalid_next;
      m_err_reg    <= m_err_next;
      m_rdata_reg  <= m_rdata_next;
      s_en_reg     <= s_en_next;
      s_rd_reg     <= s_rd_next;
      s_wr_reg     <= s_wr_next;
      s_addr_reg   <= s_addr_next;
      s_wdata_reg  <= s_wdata_next;
    end
  end

  assign m_gnt    = m_gnt_reg;
  assign m_rvalid = m_rvalid_reg;
  assign m_err    = m_err_reg;
  assign m_rdata  = m_rdata_reg;
  assign s_en     = s_en_reg;
  assign s_rd     = s_rd_reg;
  assign s_wr     = s_wr_reg;
  assign s_addr   = s_addr_reg;
  assign s_wdata  = s_wdata_reg;

endmodule

// File: tb/tb_bus_fabric.sv
// Bench for bus_fabric: directed scenarios followed by random transactions,
// each cycle's outputs compared against a transaction-level reference model.
module tb_bus_fabric;

  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int NM   = 2;
  localparam int NS   = 3;
  localparam int TO   = 16;
  localparam int SELW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     m_req, m_wr;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*DW-1:0]  m_wdata;
  logic [NM-1:0]     m_gnt, m_rvalid, m_err;
  logic [DW-1:0]     m_rdata;
  logic [NS-1:0]     s_en;
  logic              s_rd, s_wr;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [NS*DW-1:0]  s_rdata;
  logic [NS-1:0]     s_rvalid;

  int vectors     = 0;
  int miscompares = 0;
  int rr_ptr      = 0;
  int tn          = 0;

  bus_fabric #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NO_OF_MASTERS(NM),
    .NO_OF_SLAVES(NS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_err(m_err),
    .m_rdata(m_rdata), .s_en(s_en), .s_rd(s_rd), .s_wr(s_wr),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_rvalid(s_rvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic exp_out(input string tag, input logic [31:0] gnt, rv, err, rdata,
                         sen, srd, swr, saddr, swd);
    chk({tag, "/m_gnt"}, 32'(m_gnt), gnt);
    chk({tag, "/m_rvalid"}, 32'(m_rvalid), rv);
    chk({tag, "/m_err"}, 32'(m_err), err);
    chk({tag, "/m_rdata"}, 32'(m_rdata), rdata);
    chk({tag, "/s_en"}, 32'(s_en), sen);
    chk({tag, "/s_rd"}, 32'(s_rd), srd);
    chk({tag, "/s_wr"}, 32'(s_wr), swr);
    chk({tag, "/s_addr"}, 32'(s_addr), saddr);
    chk({tag, "/s_wdata"}, 32'(s_wdata), swd);
  endtask

  task automatic exp_idle(input string tag);
    exp_out(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Unrelated master activity that the fabric must ignore while busy.
  task automatic noise_masters();
    m_req   = 2'($urandom);
    m_wr    = 2'($urandom);
    m_addr  = 16'($urandom);
    m_wdata = 16'($urandom);
  endtask

  // One complete transaction, starting and ending at a negedge in IDLE.
  // d: WAIT_RD cycle (1-based) in which the slave answers; > TO means silent.
  task automatic txn(input logic [NM-1:0] mask, input logic [NM-1:0] wr,
                     input logic [NM*AW-1:0] addr, input logic [NM*DW-1:0] wdata,
                     input int d, input logic [DW-1:0] rd);
    int w, sel, iswr;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    string tag;
    tn++;
    m_req = mask; m_wr = wr; m_addr = addr; m_wdata = wdata; s_rvalid = '0;
    w = -1;
    for (int k = 0; k < NM; k++)
      if (w < 0 && mask[(rr_ptr + k) % NM]) w = (rr_ptr + k) % NM;
    rr_ptr = (w + 1) % NM;
    a    = addr[w*AW +: AW];
    wd   = wdata[w*DW +: DW];
    sel  = int'(a) >> (AW - SELW);
    iswr = int'(wr[w]);
    step();
    tag = $sformatf("txn%0d_issue", tn);
    if (sel >= NS) exp_out(tag, 1 << w, 0, 1 << w, 0, 0, 0, 0, 0, 0);
    else           exp_out(tag, 1 << w, 0, 0, 0, 1 << sel, 1 - iswr, iswr, a, wd);
    noise_masters();
    s_rvalid = '1;
    s_rdata  = 24'($urandom);
    step();
    if (sel >= NS || iswr == 1) begin
      m_req = '0; s_rvalid = '0;
      exp_idle($sformatf("txn%0d_done", tn));
      $display("txn %0d: m%0d %s addr=0x%02h", tn, w, (sel >= NS) ? "DECODE-ERR" : "write", a);
      return;
    end
    for (int k = 1; k <= TO; k++) begin
      exp_idle($sformatf("txn%0d_wait%0d", tn, k));
      noise_masters();
      s_rdata  = 24'($urandom);
      s_rvalid = 3'($urandom) & ~3'(1 << sel);
      if (k == d) begin
        s_rvalid[sel] = 1'b1;
        s_rdata[sel*DW +: DW] = rd;
      end
      step();
      if (k == d) break;
    end
    m_req = '0; s_rvalid = '0;
    tag = $sformatf("txn%0d_resp", tn);
    if (d <= TO) exp_out(tag, 0, 1 << w, 0, rd, 0, 0, 0, 0, 0);
    else         exp_out(tag, 0, 1 << w, 1 << w, 0, 0, 0, 0, 0, 0);
    $display("txn %0d: m%0d read addr=0x%02h delay=%0d %s", tn, w, a, d,
             (d <= TO) ? "data" : "timeout");
  endtask

  initial begin
    rst = 1'b1; m_req = '0; m_wr = '0; m_addr = '0; m_wdata = '0;
    s_rdata = '0; s_rvalid = '0;
    @(negedge clk);
    step(); step();
    exp_idle("reset");
    rst = 1'b0;
    step();
    exp_idle("post_reset");

    // Both masters requesting back to back: grants alternate m0, m1, m0, m1.
    for (int i = 0; i < 4; i++)
      txn(2'b11, 2'b00, {8'h40, 8'h81}, 16'h0, 2, 8'(8'h10 + i));

    // Write to slave 1.
    txn(2'b01, 2'b01, {8'h00, 8'h45}, {8'h00, 8'hA5}, 0, 8'h00);
    // Read from slave 2, answer three cycles after ISSUE.
    txn(2'b01, 2'b00, {8'h00, 8'h80}, 16'h0, 3, 8'h3C);
    // Answer in the final WAIT_RD cycle beats the timeout.
    txn(2'b10, 2'b00, {8'h90, 8'h00}, 16'h0, TO, 8'h5A);
    // Silent slave: timeout, then a late response is ignored.
    txn(2'b01, 2'b00, {8'h00, 8'h80}, 16'h0, 99, 8'h00);
    s_rvalid = 3'b100; s_rdata = 24'h123456;
    step();
    exp_idle("late_after_timeout_a");
    s_rvalid = '0;
    step();
    exp_idle("late_after_timeout_b");
    // Unmapped slave (sel=3) on read and write.
    txn(2'b01, 2'b00, {8'h00, 8'hC0}, 16'h0, 0, 8'h00);
    txn(2'b10, 2'b10, {8'hC5, 8'h00}, {8'h77, 8'h00}, 0, 8'h00);

    for (int i = 0; i < 60; i++)
      txn(2'($urandom_range(1, 3)), 2'($urandom), 16'($urandom), 16'($urandom),
          int'($urandom_range(1, 20)), 8'($urandom));

    // Reset during WAIT_RD discards the read and the pointer.
    m_req = 2'b01; m_wr = 2'b00; m_addr = 16'h0080; m_wdata = 16'h0000;
    rr_ptr = 1;
    step();
    exp_out("rst_issue", 1, 0, 0, 0, 3'b100, 1, 0, 8'h80, 0);
    m_req = '0;
    step();
    exp_idle("rst_wait1");
    step();
    exp_idle("rst_wait2");
    rst = 1'b1;
    step();
    exp_idle("rst_mid_read");
    rr_ptr = 0;
    rst = 1'b0;
    s_rvalid = 3'b100; s_rdata = 24'hABCDEF;
    step();
    exp_idle("rst_late_rvalid_a");
    s_rvalid = '0;
    step();
    exp_idle("rst_late_rvalid_b");
    $display("txn reset-during-read: discarded");
    txn(2'b11, 2'b01, {8'h41, 8'h42}, {8'h99, 8'h66}, 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_fabric.md
BUS_FABRIC -- requirements
Module: bus_fabric

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: master/slave address width in bits.
REQ-002 Parameter DATA_WIDTH, default 8: data width in bits.
REQ-003 Parameter NO_OF_MASTERS, default 2: number of requesting masters, range 1..8.
REQ-004 Parameter NO_OF_SLAVES, default 4: number of decoded slaves, range 1..8.
REQ-005 Parameter TIMEOUT, default 16: maximum slave read latency in cycles, range 2..255.
REQ-006 The block SHALL have one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  clock; all state changes on rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 m_req  in  NO_OF_MASTERS  per-master request, held until m_gnt.
REQ-010 m_wr  in  NO_OF_MASTERS  per-master access type: 1 write, 0 read.
REQ-011 m_addr  in  NO_OF_MASTERS*ADDR_WIDTH  per-master address, flattened.
REQ-012 m_wdata  in  NO_OF_MASTERS*DATA_WIDTH  per-master write data, flattened.
REQ-013 m_gnt  out  NO_OF_MASTERS  one-hot, one-cycle grant pulse.
REQ-014 m_rvalid  out  NO_OF_MASTERS  one-hot, one-cycle read-response pulse.
REQ-015 m_err  out  NO_OF_MASTERS  error qualifier, asserted with m_gnt (decode error) or m_rvalid (timeout).
REQ-016 m_rdata  out  DATA_WIDTH  read data, valid while any m_rvalid bit is set.
REQ-017 s_en  out  NO_OF_SLAVES  one-hot slave select.
REQ-018 s_rd / s_wr  out  1 each  read/write strobes, qualified by s_en.
REQ-019 s_addr / s_wdata  out  ADDR_WIDTH / DATA_WIDTH  address and write data to slaves.
REQ-020 s_rdata  in  NO_OF_SLAVES*DATA_WIDTH  per-slave read data, flattened.
REQ-021 s_rvalid  in  NO_OF_SLAVES  per-slave read-data valid pulse.

Function
REQ-022 FSM states SHALL be IDLE, ISSUE and WAIT_RD; at most one transaction is outstanding.
REQ-023 In IDLE with any m_req bit set, the winner SHALL be the first requester at or after the round-robin pointer; the winner's wr/addr/wdata are latched and the state becomes ISSUE.
REQ-024 The round-robin pointer SHALL become winner+1 modulo NO_OF_MASTERS on each grant; reset value 0.
REQ-025 Slave select SHALL be sel = the top SEL_W address bits, SEL_W = max(1, clog2(NO_OF_SLAVES)).
REQ-026 In ISSUE, m_gnt[winner] SHALL be 1 for exactly one cycle, which is one cycle after the request was sampled.
REQ-027 ISSUE with sel < NO_OF_SLAVES: s_en[sel], s_rd or s_wr, s_addr (full latched address) and s_wdata SHALL be asserted for that cycle only.
REQ-028 ISSUE with sel >= NO_OF_SLAVES: m_err[winner] SHALL be asserted with m_gnt, no slave strobe is issued, and the next state is IDLE.
REQ-029 A write SHALL go from ISSUE to IDLE; a read SHALL go to WAIT_RD with the timeout counter cleared to 0.
REQ-030 In WAIT_RD, only s_rvalid[sel] SHALL be honoured; other slaves' s_rvalid, and any s_rvalid in ISSUE, are ignored.
REQ-031 When s_rvalid[sel] is sampled, m_rvalid[winner] SHALL pulse next cycle with m_rdata = s_rdata[sel] and m_err = 0; the state becomes IDLE.
REQ-032 When WAIT_RD has lasted TIMEOUT cycles without s_rvalid[sel], m_rvalid[winner] and m_err[winner] SHALL pulse next cycle with m_rdata = 0.
REQ-033 s_rvalid arriving in the final WAIT_RD cycle SHALL take precedence over timeout.
REQ-034 A new request MAY be arbitrated in the same cycle m_rvalid pulses (IDLE), giving ISSUE on the following cycle.
REQ-035 Dropping m_req before m_gnt SHALL withdraw the request with no side effects.
REQ-036 Every output SHALL be registered; outside pulses, m_gnt, m_rvalid, m_err, s_en, s_rd and s_wr are 0.

Reset
REQ-037 On rst, the next edge SHALL force IDLE, pointer 0, counter 0 and every output to 0, including mid-transaction; a pending read is discarded.
REQ-038 s_rvalid for a read discarded by reset SHALL be ignored.

Structure
REQ-039 Package bus_pkg SHALL hold the FSM state enum; width-derived constants stay module-local.
REQ-040 Round-robin selection SHALL be in sub-module bus_rr_arbiter (req, pointer -> one-hot winner).

Verification
REQ-041 NO_OF_MASTERS=2, NO_OF_SLAVES=4: m0 writes 0x45/0xA5 -> next cycle m_gnt=01, s_en=0010, s_wr=1, s_addr=0x45, s_wdata=0xA5, for one cycle.
REQ-042 Both masters hold read requests after reset -> grants alternate m0, m1, m0, m1 over four transactions.
REQ-043 m0 reads 0x80 and slave 2 returns 0x3C three cycles after ISSUE -> m_rvalid=01, m_rdata=0x3C, m_err=0 one cycle after s_rvalid.
REQ-044 TIMEOUT=16 with a silent slave -> m_rvalid and m_err pulse after 16 WAIT_RD cycles with m_rdata=0; a later s_rvalid is ignored.
REQ-045 NO_OF_SLAVES=3 and address 0xC0 (sel=3) -> m_gnt and m_err pulse together with s_en=000.
REQ-046 rst asserted during WAIT_RD -> all outputs 0 next cycle, IDLE state, and a late s_rvalid produces no m_rvalid.
